// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU command at a time over a valid/ready port,
// drives registered operands to the ALU, waits the ALU's fixed latency,
// captures the result and returns it over a valid/ready response port.
// Illegal func codes are answered at once with an error response, and the
// ALU operands are left untouched.
module alu_op_sequencer #(
    parameter int N        = 10,
    parameter int FUNC_W   = 5,
    parameter int NUM_FUNC = 16,
    parameter int LAT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [N-1:0]      cmd_a,
    input  logic [N-1:0]      cmd_b,
    input  logic [FUNC_W-1:0] cmd_func,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [N*N-1:0]    alu_f,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N*N-1:0]    rsp_f,
    output logic              rsp_err,
    output logic [15:0]       op_count
);

    // Wide enough to hold LAT; at least one bit so LAT=0 still elaborates.
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT + 1) : 1;
    // One extra bit so NUM_FUNC = 2**FUNC_W (every code legal) is representable.
    localparam logic [FUNC_W:0] NUM_FUNC_W = (FUNC_W + 1)'(NUM_FUNC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N-1:0]        alu_a_q, alu_a_d;
    logic [N-1:0]        alu_b_q, alu_b_d;
    logic [FUNC_W-1:0]   alu_func_q, alu_func_d;
    logic [N*N-1:0]      rsp_f_q, rsp_f_d;
    logic                rsp_err_q, rsp_err_d;
    logic [15:0]         op_count_q, op_count_d;
    logic                func_legal;

    assign func_legal = ({1'b0, cmd_func} < NUM_FUNC_W);

    // Next-state and datapath updates for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_func_d = alu_func_q;
        rsp_f_d    = rsp_f_q;
        rsp_err_d  = rsp_err_q;
        op_count_d = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (func_legal) begin
                        alu_a_d    = cmd_a;
                        alu_b_d    = cmd_b;
                        alu_func_d = cmd_func;
                        cnt_d      = CNT_W'(LAT);
                        state_d    = ST_WAIT;
                    end else begin
                        // Answer immediately; the ALU keeps its previous operands.
                        rsp_f_d   = '0;
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_f_d   = alu_f;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_func_q <= '0;
            rsp_f_q    <= '0;
            rsp_err_q  <= 1'b0;
            op_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge value, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_func_q <= alu_func_d;
            rsp_f_q    <= rsp_f_d;
            rsp_err_q  <= rsp_err_d;
            op_count_q <= op_count_d;
        end
    end

    // cmd_ready follows the state, so it reads 1 while reset holds the FSM in IDLE.
    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_func  = alu_func_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: three instances (LAT=1, LAT=0, LAT=3), each
// with a multiply stub ALU of matching latency. Expected responses are pushed
// to a scoreboard when a command is accepted and popped when it returns.
module tb_alu_op_sequencer;

    localparam int N  = 10;
    localparam int FW = 5;
    localparam int NI = 3;

    typedef struct {
        int             inst;
        logic [N*N-1:0] f;
        logic           err;
        int             lat;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid [NI];
    logic              cmd_ready [NI];
    logic [N-1:0]      cmd_a     [NI];
    logic [N-1:0]      cmd_b     [NI];
    logic [FW-1:0]     cmd_func  [NI];
    logic [N-1:0]      alu_a     [NI];
    logic [N-1:0]      alu_b     [NI];
    logic [FW-1:0]     alu_func  [NI];
    logic [N*N-1:0]    alu_f     [NI];
    logic              rsp_valid [NI];
    logic              rsp_ready [NI];
    logic [N*N-1:0]    rsp_f     [NI];
    logic              rsp_err   [NI];
    logic [15:0]       op_count  [NI];

    logic [N*N-1:0]    s1 [NI];
    logic [N*N-1:0]    s2 [NI];
    logic [N*N-1:0]    s3 [NI];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
        return (N*N)'(a) * (N*N)'(b);
    endfunction

    // Stub ALU pipelines: F = A*B delayed by the instance latency.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            s1[i] <= prod(alu_a[i], alu_b[i]);
            s2[i] <= s1[i];
            s3[i] <= s2[i];
        end
    end

    assign alu_f[0] = s1[0];
    assign alu_f[1] = prod(alu_a[1], alu_b[1]);
    assign alu_f[2] = s3[2];

    alu_op_sequencer #(.N(N), .FUNC_W(FW), .NUM_FUNC(16), .LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_func(cmd_func[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_func(alu_func[0]), .alu_f(alu_f[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_f(rsp_f[0]), .rsp_err(rsp_err[0]), .op_count(op_count[0])
    );

    alu_op_sequencer #(.N(N), .FUNC_W(FW), .NUM_FUNC(16), .LAT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_func(cmd_func[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_func(alu_func[1]), .alu_f(alu_f[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_f(rsp_f[1]), .rsp_err(rsp_err[1]), .op_count(op_count[1])
    );

    alu_op_sequencer #(.N(N), .FUNC_W(FW), .NUM_FUNC(16), .LAT(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_a(cmd_a[2]), .cmd_b(cmd_b[2]), .cmd_func(cmd_func[2]),
        .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_func(alu_func[2]), .alu_f(alu_f[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_f(rsp_f[2]), .rsp_err(rsp_err[2]), .op_count(op_count[2])
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge, wait for acceptance (bounded), push the
    // expected response, and return at the negedge after the accepting edge.
    task automatic send_cmd(input int i, input int a, input int b, input int func,
                            input logic [N*N-1:0] exp_f, input logic exp_err, input int exp_lat);
        exp_t e;
        int   guard;
        cmd_valid[i] = 1'b1;
        cmd_a[i]     = N'(a);
        cmd_b[i]     = N'(b);
        cmd_func[i]  = FW'(func);
        guard = 0;
        while (!cmd_ready[i] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_accept_timeout", 128'(guard < 20), 128'(1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid[i] = 1'b0;
        e.inst = i;
        e.f    = exp_f;
        e.err  = exp_err;
        e.lat  = exp_lat;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and wait (bounded) for the matching response.
    task automatic wait_rsp(input int i);
        exp_t e;
        int   m;
        check("sb_nonempty", 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_inst", 128'(e.inst), 128'(i));
            m = 0;
            while (!rsp_valid[i] && m < 20) begin
                @(negedge clk);
                m++;
            end
            check("rsp_latency", 128'(m), 128'(e.lat));
            check("rsp_f", 128'(rsp_f[i]), 128'(e.f));
            check("rsp_err", 128'(rsp_err[i]), 128'(e.err));
            check("cmd_ready_busy", 128'(cmd_ready[i]), 128'(0));
        end
    endtask

    // Response handshake, then confirm return to IDLE and the counter value.
    task automatic rsp_take(input int i, input logic [15:0] exp_count);
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        check("op_count", 128'(op_count[i]), 128'(exp_count));
        check("rsp_valid_drop", 128'(rsp_valid[i]), 128'(0));
        check("cmd_ready_idle", 128'(cmd_ready[i]), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_a[i]     = '0;
            cmd_b[i]     = '0;
            cmd_func[i]  = '0;
            rsp_ready[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_alu_a", 128'(alu_a[0]), 128'(0));
        check("rst_alu_func", 128'(alu_func[0]), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid[0]), 128'(0));
        check("rst_rsp_f", 128'(rsp_f[0]), 128'(0));
        check("rst_op_count", 128'(op_count[0]), 128'(0));
        check("rst_cmd_ready", 128'(cmd_ready[0]), 128'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operation, LAT=1: 23*13 = 299
        send_cmd(0, 23, 13, 2, 100'd299, 1'b0, 2);
        check("t1_alu_a", 128'(alu_a[0]), 128'(23));
        check("t1_alu_b", 128'(alu_b[0]), 128'(13));
        check("t1_alu_func", 128'(alu_func[0]), 128'(2));
        wait_rsp(0);
        rsp_take(0, 16'd1);

        // Backpressure with a competing command held on the input
        send_cmd(0, 14, 1, 7, 100'd14, 1'b0, 2);
        wait_rsp(0);
        cmd_valid[0] = 1'b1;
        cmd_a[0]     = 10'd5;
        cmd_b[0]     = 10'd5;
        cmd_func[0]  = 5'd3;
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 128'(rsp_valid[0]), 128'(1));
            check("bp_rsp_f", 128'(rsp_f[0]), 128'(14));
            check("bp_cmd_ready", 128'(cmd_ready[0]), 128'(0));
            check("bp_alu_a", 128'(alu_a[0]), 128'(14));
        end
        cmd_valid[0] = 1'b0;
        rsp_take(0, 16'd2);

        // Illegal func: immediate error response, ALU operands untouched
        send_cmd(0, 22, 7, 20, 100'd0, 1'b1, 0);
        check("ill_alu_a", 128'(alu_a[0]), 128'(14));
        check("ill_alu_b", 128'(alu_b[0]), 128'(1));
        check("ill_alu_func", 128'(alu_func[0]), 128'(7));
        wait_rsp(0);
        rsp_take(0, 16'd3);

        // Func boundary: 15 is legal (max operands), 16 is illegal
        send_cmd(0, 1023, 1023, 15, 100'd1046529, 1'b0, 2);
        check("b15_alu_func", 128'(alu_func[0]), 128'(15));
        wait_rsp(0);
        rsp_take(0, 16'd4);
        send_cmd(0, 2, 3, 16, 100'd0, 1'b1, 0);
        check("b16_alu_func", 128'(alu_func[0]), 128'(15));
        wait_rsp(0);
        rsp_take(0, 16'd5);

        // Reset while in WAIT: everything clears, no response follows
        send_cmd(0, 11, 9, 9, 100'd99, 1'b0, 2);
        rst_n = 1'b0;
        #1;
        check("mid_alu_a", 128'(alu_a[0]), 128'(0));
        check("mid_alu_b", 128'(alu_b[0]), 128'(0));
        check("mid_alu_func", 128'(alu_func[0]), 128'(0));
        check("mid_rsp_valid", 128'(rsp_valid[0]), 128'(0));
        check("mid_rsp_err", 128'(rsp_err[0]), 128'(0));
        check("mid_op_count", 128'(op_count[0]), 128'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mid_no_rsp", 128'(rsp_valid[0]), 128'(0));
        end
        send_cmd(0, 3, 4, 1, 100'd12, 1'b0, 2);
        wait_rsp(0);
        rsp_take(0, 16'd1);

        // Latency sweep: LAT=0 and LAT=3
        send_cmd(1, 7, 8, 0, 100'd56, 1'b0, 1);
        wait_rsp(1);
        rsp_take(1, 16'd1);
        send_cmd(2, 31, 17, 5, 100'd527, 1'b0, 4);
        wait_rsp(2);
        rsp_take(2, 16'd1);

        // Counter wrap 0xFFFF -> 0x0000
        force u_dut0.op_count_q = 16'hFFFF;
        @(negedge clk);
        release u_dut0.op_count_q;
        @(negedge clk);
        check("wrap_preload", 128'(op_count[0]), 128'(16'hFFFF));
        send_cmd(0, 5, 6, 3, 100'd30, 1'b0, 2);
        wait_rsp(0);
        rsp_take(0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
